pipe_irq_ctrl: RTL and testbench

- Sequences interrupt and exception entry/exit for the 5-stage pipelined CPU.
- Watches the external interrupt line and the ID-stage undefined-instruction flag. Picks a safe ID-stage instruction, flushes IF/ID/EX, redirects PC to the vector, and supplies the return address for $26 (xp).
- Masks further entries until the kernel-exit jump.
- Sits beside Hazard/Forward. Its outputs override PCSrc and the flush controls.

---
 rtl/irq_pkg.sv | 29 ++
 rtl/irq_sync.sv | 33 +++
 rtl/pipe_irq_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_irq_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and default vectors for the pipeline
// interrupt/exception sequencer.
package irq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    TAKE,
    DRAIN,
    KERNEL
  } state_e;

  typedef enum logic {
    CAUSE_IRQ,
    CAUSE_EXC
  } cause_e;

  localparam logic [31:0] DEF_IRQ_VECTOR = 32'h0000_0004;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0008;

  // IRQ resumes the interrupted instruction; EXC skips it.
  function automatic logic [31:0] epc_of(
    input cause_e      c,
    input logic [31:0] pc
  );
    return (c == CAUSE_EXC) ? pc + 32'd4 : pc;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_in synchroniser plus re-arm qualifier: a level is only
// accepted again once the synchronised line has been seen low.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic take_i,
  output logic irq_s_o,
  output logic armed_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      armed_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      if (take_i)
        armed_q <= 1'b0;
      else if (!sync_q[SYNC_STAGES-1])
        armed_q <= 1'b1;
    end
  end

  assign irq_s_o = sync_q[SYNC_STAGES-1];
  assign armed_o = armed_q;

endmodule

// File: rtl/pipe_irq_ctrl.sv
// Interrupt/exception entry and exit sequencer that
// overrides PC select and pipeline flushes.
module pipe_irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [31:0] IRQ_VECTOR   = DEF_IRQ_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int          SYNC_STAGES  = 2,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_in,
  input  logic        exc_id,
  input  logic        id_valid,
  input  logic        stall_in,
  input  logic [31:0] pc_id,
  input  logic        kernel_exit,
  output logic        redirect,
  output logic [31:0] vec_pc,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        epc_we,
  output logic [31:0] epc,
  output logic        in_kernel,
  output logic        fault
);

  state_e      state_q;
  cause_e      cause_q;
  cause_e      cause_arm;
  logic [2:0]  cnt_q;
  logic        pend_q;
  logic        pend_d;
  logic        irq_s;
  logic        armed;
  logic        take_irq;
  logic        safe;
  logic        redirect_q;
  logic        flush_if_q;
  logic        flush_id_q;
  logic        flush_ex_q;
  logic        epc_we_q;
  logic        in_kernel_q;
  logic        fault_q;
  logic [31:0] vec_pc_q;
  logic [31:0] epc_q;

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .take_i (take_irq),
    .irq_s_o(irq_s),
    .armed_o(armed)
  );

  assign take_irq  = (state_q == TAKE) && (cause_q == CAUSE_IRQ);
  assign pend_d    = take_irq ? 1'b0 : (pend_q | (irq_s & armed));
  assign safe      = id_valid & ~stall_in;
  assign cause_arm = exc_id ? CAUSE_EXC : cause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cause_q     <= CAUSE_IRQ;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      redirect_q  <= 1'b0;
      flush_if_q  <= 1'b0;
      flush_id_q  <= 1'b0;
      flush_ex_q  <= 1'b0;
      epc_we_q    <= 1'b0;
      in_kernel_q <= 1'b0;
      fault_q     <= 1'b0;
      vec_pc_q    <= '0;
      epc_q       <= '0;
    end else begin
      pend_q     <= pend_d;
      redirect_q <= 1'b0;
      flush_if_q <= 1'b0;
      flush_id_q <= 1'b0;
      flush_ex_q <= 1'b0;
      epc_we_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (exc_id) begin
            cause_q <= CAUSE_EXC;
            state_q <= ARM;
          end else if (pend_d) begin
            cause_q <= CAUSE_IRQ;
            state_q <= ARM;
          end
        end
        ARM: begin
          cause_q <= cause_arm;
          if (safe) begin
            state_q     <= TAKE;
            epc_q       <= epc_of(cause_arm, pc_id);
            vec_pc_q    <= (cause_arm == CAUSE_EXC) ? EXC_VECTOR
                                                     : IRQ_VECTOR;
            redirect_q  <= 1'b1;
            flush_if_q  <= 1'b1;
            flush_id_q  <= 1'b1;
            flush_ex_q  <= (cause_arm == CAUSE_EXC);
            epc_we_q    <= 1'b1;
            in_kernel_q <= 1'b1;
          end
        end
        TAKE: begin
          state_q <= DRAIN;
          cnt_q   <= 3'(DRAIN_CYCLES);
        end
        DRAIN: begin
          if (cnt_q == 3'd1)
            state_q <= KERNEL;
          else
            cnt_q <= cnt_q - 3'd1;
        end
        KERNEL: begin
          // Exit beats a same-cycle illegal instruction.
          if (kernel_exit) begin
            state_q     <= IDLE;
            in_kernel_q <= 1'b0;
          end else if (exc_id) begin
            fault_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign redirect  = redirect_q;
  assign vec_pc    = vec_pc_q;
  assign flush_if  = flush_if_q;
  assign flush_id  = flush_id_q;
  assign flush_ex  = flush_ex_q;
  assign epc_we    = epc_we_q;
  assign epc       = epc_q;
  assign in_kernel = in_kernel_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_pipe_irq_ctrl.sv
// Scenario bench for pipe_irq_ctrl: expected vector entries
// are queued at stimulus time and popped on each redirect.
module tb_pipe_irq_ctrl;

  typedef struct {
    logic [31:0] vec;
    logic [31:0] epc;
    logic        fex;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_in;
  logic        exc_id;
  logic        id_valid;
  logic        stall_in;
  logic [31:0] pc_id;
  logic        kernel_exit;
  logic        redirect;
  logic [31:0] vec_pc;
  logic        flush_if;
  logic        flush_id;
  logic        flush_ex;
  logic        epc_we;
  logic [31:0] epc;
  logic        in_kernel;
  logic        fault;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  pipe_irq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .exc_id     (exc_id),
    .id_valid   (id_valid),
    .stall_in   (stall_in),
    .pc_id      (pc_id),
    .kernel_exit(kernel_exit),
    .redirect   (redirect),
    .vec_pc     (vec_pc),
    .flush_if   (flush_if),
    .flush_id   (flush_id),
    .flush_ex   (flush_ex),
    .epc_we     (epc_we),
    .epc        (epc),
    .in_kernel  (in_kernel),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_redirect(input int budget,
                               output int n,
                               output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (redirect === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic count_redirects(input int cyc, output int hits);
    hits = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (redirect === 1'b1) hits++;
    end
  endtask

  task automatic leave_kernel();
    exc_id = 1'b0;
    repeat (3) tick();
    kernel_exit = 1'b1;
    tick();
    kernel_exit = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_in = 1'b0; exc_id = 1'b0;
    id_valid = 1'b1; stall_in = 1'b0;
    pc_id = 32'h0; kernel_exit = 1'b0;
    repeat (2) tick();
    checks++;
    if ({redirect, flush_if, flush_id, flush_ex, epc_we,
         in_kernel, fault} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0",
               {redirect, flush_if, flush_id, flush_ex,
                epc_we, in_kernel, fault});
    end
    checks++;
    if (vec_pc !== 32'h0 || epc !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: vec %h epc %h want 0",
               vec_pc, epc);
    end
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (redirect !== 1'b0 || in_kernel !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: redir %b kern %b want 0",
               redirect, in_kernel);
    end
  endtask

  task automatic test_irq_latency();
    int n, hits;
    bit seen;
    exp_t e;
    pc_id = 32'h40;
    repeat (4) tick();
    irq_in = 1'b1;
    sbq.push_back('{32'h4, 32'h40, 1'b0});
    wait_redirect(10, n, seen);
    checks++;
    if (!seen || n != 4) begin
      errors++;
      $display("FAIL irq_latency: %0d cycles seen %b want 4",
               n, seen);
    end
    e = sbq.pop_front();
    checks++;
    if (vec_pc !== e.vec || epc !== e.epc ||
        flush_ex !== e.fex || epc_we !== 1'b1 ||
        flush_if !== 1'b1 || flush_id !== 1'b1 ||
        in_kernel !== 1'b1) begin
      errors++;
      $display("FAIL irq_take: vec %h epc %h fex %b we %b kern %b want %h %h %b 1 1",
               vec_pc, epc, flush_ex, epc_we, in_kernel,
               e.vec, e.epc, e.fex);
    end
    tick();
    checks++;
    if (redirect !== 1'b0 || epc_we !== 1'b0 ||
        in_kernel !== 1'b1) begin
      errors++;
      $display("FAIL irq_pulse: redir %b we %b kern %b want 0 0 1",
               redirect, epc_we, in_kernel);
    end
    repeat (2) tick();
    kernel_exit = 1'b1;
    tick();
    kernel_exit = 1'b0;
    checks++;
    if (in_kernel !== 1'b0) begin
      errors++;
      $display("FAIL irq_exit: kern %b want 0", in_kernel);
    end
    count_redirects(8, hits);
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL irq_held_retake: %0d redirects want 0", hits);
    end
    irq_in = 1'b0;
    repeat (4) tick();
    pc_id = 32'h100;
    irq_in = 1'b1;
    sbq.push_back('{32'h4, 32'h100, 1'b0});
    wait_redirect(10, n, seen);
    e = sbq.pop_front();
    checks++;
    if (!seen || n != 4 || epc !== e.epc || vec_pc !== e.vec) begin
      errors++;
      $display("FAIL irq_rearm: n %0d epc %h vec %h want 4 %h %h",
               n, epc, vec_pc, e.epc, e.vec);
    end
    irq_in = 1'b0;
    leave_kernel();
    repeat (3) tick();
  endtask

  task automatic test_exc();
    int n;
    bit seen;
    exp_t e;
    pc_id = 32'h7C;
    exc_id = 1'b1;
    sbq.push_back('{32'h8, 32'h80, 1'b1});
    wait_redirect(6, n, seen);
    exc_id = 1'b0;
    checks++;
    if (!seen || n != 2) begin
      errors++;
      $display("FAIL exc_latency: %0d cycles seen %b want 2",
               n, seen);
    end
    e = sbq.pop_front();
    checks++;
    if (vec_pc !== e.vec || epc !== e.epc ||
        flush_ex !== e.fex || flush_if !== 1'b1 ||
        flush_id !== 1'b1 || epc_we !== 1'b1) begin
      errors++;
      $display("FAIL exc_take: vec %h epc %h fl %b%b%b we %b want %h %h 111 1",
               vec_pc, epc, flush_if, flush_id, flush_ex,
               epc_we, e.vec, e.epc);
    end
    leave_kernel();
  endtask

  task automatic test_stall();
    int n, hits;
    bit seen;
    exp_t e;
    stall_in = 1'b1;
    irq_in = 1'b1;
    hits = 0;
    for (int i = 0; i < 7; i++) begin
      pc_id = 32'h200 + 32'(4 * i);
      tick();
      if (redirect === 1'b1) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d redirects want 0", hits);
    end
    pc_id = 32'h2A0;
    stall_in = 1'b0;
    sbq.push_back('{32'h4, 32'h2A0, 1'b0});
    wait_redirect(3, n, seen);
    e = sbq.pop_front();
    checks++;
    if (!seen || n != 1 || epc !== e.epc || vec_pc !== e.vec ||
        flush_ex !== e.fex) begin
      errors++;
      $display("FAIL stall_take: n %0d epc %h vec %h want 1 %h %h",
               n, epc, vec_pc, e.epc, e.vec);
    end
    irq_in = 1'b0;
    leave_kernel();
    repeat (3) tick();
  endtask

  task automatic test_upgrade_pending();
    int n;
    bit seen;
    exp_t e;
    id_valid = 1'b0;
    pc_id = 32'h500;
    irq_in = 1'b1;
    repeat (5) tick();
    checks++;
    if (redirect !== 1'b0) begin
      errors++;
      $display("FAIL bubble_hold: redir %b want 0", redirect);
    end
    exc_id = 1'b1;
    id_valid = 1'b1;
    pc_id = 32'h504;
    sbq.push_back('{32'h8, 32'h508, 1'b1});
    wait_redirect(3, n, seen);
    exc_id = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (!seen || n != 1 || vec_pc !== e.vec || epc !== e.epc ||
        flush_ex !== e.fex) begin
      errors++;
      $display("FAIL upgrade: n %0d vec %h epc %h fex %b want 1 %h %h %b",
               n, vec_pc, epc, flush_ex, e.vec, e.epc, e.fex);
    end
    repeat (3) tick();
    pc_id = 32'h600;
    sbq.push_back('{32'h4, 32'h600, 1'b0});
    kernel_exit = 1'b1;
    tick();
    kernel_exit = 1'b0;
    wait_redirect(5, n, seen);
    e = sbq.pop_front();
    checks++;
    if (!seen || n != 2 || vec_pc !== e.vec || epc !== e.epc) begin
      errors++;
      $display("FAIL pending_after_exit: n %0d vec %h epc %h want 2 %h %h",
               n, vec_pc, epc, e.vec, e.epc);
    end
    irq_in = 1'b0;
    leave_kernel();
    repeat (3) tick();
  endtask

  task automatic test_fault_reset();
    int n, hits;
    bit seen;
    exp_t e;
    pc_id = 32'h300;
    exc_id = 1'b1;
    sbq.push_back('{32'h8, 32'h304, 1'b1});
    wait_redirect(6, n, seen);
    exc_id = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (!seen || epc !== e.epc || vec_pc !== e.vec) begin
      errors++;
      $display("FAIL fault_entry: seen %b epc %h vec %h want 1 %h %h",
               seen, epc, vec_pc, e.epc, e.vec);
    end
    repeat (3) tick();
    exc_id = 1'b1;
    tick();
    exc_id = 1'b0;
    count_redirects(4, hits);
    checks++;
    if (fault !== 1'b1 || hits != 0 || in_kernel !== 1'b1) begin
      errors++;
      $display("FAIL kernel_fault: fault %b redirs %0d kern %b want 1 0 1",
               fault, hits, in_kernel);
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({redirect, flush_if, flush_id, flush_ex, epc_we,
         in_kernel, fault} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_kernel: got %b want 0",
               {redirect, flush_if, flush_id, flush_ex,
                epc_we, in_kernel, fault});
    end
    pc_id = 32'h400;
    exc_id = 1'b1;
    tick();
    reset = 1'b1;
    exc_id = 1'b0;
    hits = 0;
    repeat (2) begin
      tick();
      if (epc_we === 1'b1 || redirect === 1'b1) hits++;
    end
    reset = 1'b0;
    repeat (4) begin
      tick();
      if (epc_we === 1'b1 || redirect === 1'b1) hits++;
    end
    checks++;
    if (hits != 0 || in_kernel !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_entry: pulses %0d kern %b want 0 0",
               hits, in_kernel);
    end
  endtask

  task automatic test_wrap_exit_wins();
    int n, hits;
    bit seen;
    exp_t e;
    pc_id = 32'hFFFF_FFFC;
    exc_id = 1'b1;
    sbq.push_back('{32'h8, 32'h0, 1'b1});
    wait_redirect(6, n, seen);
    exc_id = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (!seen || n != 2 || epc !== e.epc || vec_pc !== e.vec) begin
      errors++;
      $display("FAIL epc_wrap: n %0d epc %h vec %h want 2 %h %h",
               n, epc, vec_pc, e.epc, e.vec);
    end
    repeat (3) tick();
    kernel_exit = 1'b1;
    exc_id = 1'b1;
    tick();
    kernel_exit = 1'b0;
    exc_id = 1'b0;
    checks++;
    if (fault !== 1'b0 || in_kernel !== 1'b0) begin
      errors++;
      $display("FAIL exit_wins: fault %b kern %b want 0 0",
               fault, in_kernel);
    end
    count_redirects(5, hits);
    checks++;
    if (hits != 0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL quiet_after_exit: redirs %0d queued %0d want 0 0",
               hits, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_irq_latency();
    test_exc();
    test_stall();
    test_upgrade_pending();
    test_fault_reset();
    test_wrap_exit_wins();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
